// File: rtl/operand_issue.sv
// operand_issue: ID-to-EX operand stage.
// Resolves rs1/rs2 from the regfile plus the MEM/WB bypass paths, detects
// load-use hazards, and holds the ID/EX register behind a valid/ready
// handshake. It also keeps a saturating count of the bubbles it inserts.
module operand_issue #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // ID side
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  // Regfile read data
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic [XLEN-1:0]  rf_rd2,
  // Bypass sources
  input  logic             mem_fwd_valid,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_wd,
  // Control
  input  logic             flush,
  input  logic             ex_ready,
  // EX register outputs
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_is_load,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  // EX register state
  logic             ex_valid_q,     ex_valid_d;
  logic [XLEN-1:0]  ex_op1_q,       ex_op1_d;
  logic [XLEN-1:0]  ex_op2_q,       ex_op2_d;
  logic [4:0]       ex_rd_q,        ex_rd_d;
  logic             ex_reg_write_q, ex_reg_write_d;
  logic             ex_is_load_q,   ex_is_load_d;
  logic [XLEN-1:0]  ex_imm_q,       ex_imm_d;
  logic [XLEN-1:0]  ex_pc_q,        ex_pc_d;
  logic [CNT_W-1:0] stall_cnt_q,    stall_cnt_d;

  // Resolved operands and handshake terms
  logic [XLEN-1:0] op1_res;
  logic [XLEN-1:0] op2_res;
  logic            advance;
  logic            hazard;
  logic            rs1_hit;
  logic            rs2_hit;

  // Bypass priority: x0, then MEM (youngest), then WB (same-cycle write
  // not yet visible in the regfile), then the regfile itself.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf_val
  );
    logic [XLEN-1:0] val;
    if (idx == 5'd0) begin
      val = '0;
    end else if (mem_fwd_valid && (mem_rd == idx)) begin
      val = mem_data;
    end else if (wb_we && (wb_rd == idx)) begin
      val = wb_wd;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  // Operand resolution, hazard detection and ready generation
  always_comb begin
    op1_res  = resolve(id_rs1, rf_rd1);
    op2_res  = resolve(id_rs2, rf_rd2);
    advance  = ex_ready | ~ex_valid_q;
    rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd_q);
    rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd_q);
    hazard   = id_valid & ex_valid_q & ex_is_load_q & ex_reg_write_q &
               (ex_rd_q != 5'd0) & (rs1_hit | rs2_hit);
    id_ready = flush | (advance & ~hazard);
  end

  // Next-state for the EX register and the stall counter
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_op1_d       = ex_op1_q;
    ex_op2_d       = ex_op2_q;
    ex_rd_d        = ex_rd_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_is_load_d   = ex_is_load_q;
    ex_imm_d       = ex_imm_q;
    ex_pc_d        = ex_pc_q;
    stall_cnt_d    = stall_cnt_q;
    if (flush) begin
      // Flush kills EX and discards the ID instruction; data fields hold.
      ex_valid_d = 1'b0;
    end else if (!advance) begin
      // EX is backpressured: everything holds.
      ex_valid_d = ex_valid_q;
    end else if (hazard) begin
      // Load-use: insert a bubble and count it, saturating at all-ones.
      ex_valid_d = 1'b0;
      if (!(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else begin
      ex_valid_d     = id_valid;
      ex_op1_d       = op1_res;
      ex_op2_d       = op2_res;
      ex_rd_d        = id_rd;
      ex_reg_write_d = id_reg_write;
      ex_is_load_d   = id_is_load;
      ex_imm_d       = id_imm;
      ex_pc_d        = id_pc;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_op1_q       <= '0;
      ex_op2_q       <= '0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_imm_q       <= '0;
      ex_pc_q        <= '0;
      stall_cnt_q    <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_op1_q       <= ex_op1_d;
      ex_op2_q       <= ex_op2_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_is_load_q   <= ex_is_load_d;
      ex_imm_q       <= ex_imm_d;
      ex_pc_q        <= ex_pc_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_op1       = ex_op1_q;
  assign ex_op2       = ex_op2_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_is_load   = ex_is_load_q;
  assign ex_imm       = ex_imm_q;
  assign ex_pc        = ex_pc_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- ID-to-EX operand stage that sits directly downstream of the register file.
- Resolves the rs1/rs2 operand values from regfile read data plus bypass paths (MEM result, WB write), and forces x0 to zero.
- Detects load-use hazards and inserts bubbles.
- Holds the ID/EX pipeline register behind a valid/ready handshake.
- Counts stall cycles for performance monitoring.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decoded instruction present.
- id_ready  out  1  stage accepts the ID instruction this cycle.
- id_rs1, id_rs2  in  5  source register indices (same indices driven to the regfile).
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads that source.
- id_rd  in  5  destination index.
- id_reg_write  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_imm  in  XLEN  decoded immediate.
- id_pc  in  XLEN  instruction PC.
- rf_rd1, rf_rd2  in  XLEN  regfile read data for id_rs1/id_rs2.
- mem_fwd_valid  in  1  MEM stage holds a register-writing result that is ready to forward.
- mem_rd  in  5  MEM destination index.
- mem_data  in  XLEN  MEM result.
- wb_we, wb_rd, wb_wd  in  1/5/XLEN  WB write, same signals that drive the regfile write port.
- flush  in  1  discard the ID instruction and the EX register contents.
- ex_ready  in  1  EX accepts the current EX register contents.
- ex_valid  out  1  EX register holds a valid instruction.
- ex_op1, ex_op2  out  XLEN  resolved operands.
- ex_rd  out  5  latched destination index.
- ex_reg_write  out  1  latched write flag.
- ex_is_load  out  1  latched load flag.
- ex_imm, ex_pc  out  XLEN  latched immediate and PC.
- stall_cnt  out  CNT_W  count of load-use bubbles inserted.

Behaviour:
- Reset (rst=1 at clk edge): ex_valid=0; all ex_* data outputs =0; stall_cnt=0. Reset mid-stall drops the EX instruction and the pending hazard; first post-reset cycle shows id_ready=1.
- Operand resolution is combinational. Priority per source, highest first:
  1. index==0 → 0 (regardless of regfile contents or bypass).
  2. mem_fwd_valid & mem_rd==index → mem_data.
  3. wb_we & wb_rd==index → wb_wd. Covers the same-cycle write, since regfile updates only at the edge.
  4. Otherwise rf_rd1/rf_rd2.
- advance = ex_ready | ~ex_valid.
- hazard = id_valid & ex_valid & ex_is_load & ex_reg_write & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - A source with id_uses_rsN=0 never triggers hazard.
- id_ready = flush | (advance & ~hazard).
- EX register update at clk edge, priority order:
  1. rst.
  2. flush → ex_valid<=0; data fields don't-care (held). The ID instruction counts as consumed (discarded).
  3. ~advance → hold all ex_* outputs.
  4. hazard → ex_valid<=0 (bubble); stall_cnt increments.
  5. Otherwise → ex_valid<=id_valid; ex_* <= resolved operands and ID fields.
- While stalled, the ID instruction waits with id_valid held. Its operands are re-resolved every cycle, so WB/MEM updates during the stall are picked up.
- stall_cnt increments by 1 per bubble cycle and saturates at all-ones; it never wraps.
  - A cycle with hazard but ~advance is not counted.
  - A cycle with flush & hazard is not counted.
- Latency: one cycle from ID acceptance to ex_valid.
- Load-use resolves in exactly one bubble when ex_ready=1, because the load then moves to MEM and is forwarded via mem_fwd_valid.

Test Plan:
- Reset then id_valid=1, rs1=3, rs2=0, rf_rd1=0x11, rf_rd2=0xFFFF → next cycle: ex_valid=1, ex_op1=0x11, ex_op2=0; stall_cnt=0.
- Bypass priority: rs1=5 with rf_rd1=0xA, wb_we=1, wb_rd=5, wb_wd=0xB, and mem_fwd_valid=1, mem_rd=5, mem_data=0xC → ex_op1=0xC. Drop mem_fwd_valid → 0xB. Drop wb_we → 0xA.
- Load-use: EX holds a load with rd=7, ID reads rs2=7, ex_ready=1 → id_ready=0 for 1 cycle, ex_valid=0 the next cycle, stall_cnt=1. With mem_fwd_valid=1, mem_rd=7, mem_data=0x55 the following cycle → ex_op2=0x55.
- Backpressure: ex_valid=1, ex_ready=0 for 3 cycles with a new ID instruction present → id_ready=0 and ex_* unchanged throughout. On ex_ready=1 the new instruction is latched one cycle later.
- flush=1 during a load-use stall → id_ready=1, ex_valid=0 next cycle, stall_cnt unchanged.
- Force stall_cnt to all-ones (CNT_W=4 build: 15 bubbles), then one more bubble → stall_cnt stays 15.
